// File: rtl/jtframe_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_pkg
//  Description : Shared types for the frame tracker / dump-window generator.
//                Holds the window FSM state encoding and the start-mode
//                constants used by cfg_mode.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_dump_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_DL = 3'd1,
        ARMED   = 3'd2,
        DUMP    = 3'd3,
        DONE    = 3'd4
    } dump_state_t;

    // cfg_mode encodings
    localparam logic MODE_FRAME = 1'b0;   // open at frame cfg_start
    localparam logic MODE_DL    = 1'b1;   // open when a download ends

endpackage
`default_nettype wire

// File: rtl/jtframe_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_sync_edge
//  Description : Multi-flop synchronizer for an asynchronous level, followed
//                by an edge detector with registered one-cycle rise/fall
//                pulses.
//  Ports       : clk, rst_n   clock / asynchronous active-low reset
//                i_d          asynchronous input level
//                o_level      synchronized level, aligned with the pulses
//                o_rise       one-cycle pulse on a synchronized 0->1
//                o_fall       one-cycle pulse on a synchronized 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_sync_edge #(
    parameter int SYNC_STAGES = 2
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // r_prev is the extra flop behind the last sync stage; the pulses are
    // registered so a change sampled at edge k is reported in cycle
    // k+SYNC_STAGES, with o_level already showing the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <=  r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] &  r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/jtframe_dump_trig.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_trig
//  Description : Frame tracker and dump-window generator. Counts frames from
//                vertical sync, follows the ROM-download flag and opens a
//                dump window either at a programmed frame or at the end of a
//                download, for a programmed number of frames.
//  Ports       : clk, rst_n     clock / asynchronous active-low reset
//                vs             vertical sync (asynchronous)
//                downloading    ROM download in progress (asynchronous)
//                cfg_mode       0: start at cfg_start, 1: start at download end
//                cfg_start      frame number that opens the window (mode 0)
//                cfg_len        window length in frames, 0 = unlimited
//                frame_cnt      current frame number
//                frame_stb      one-cycle pulse per frame edge
//                dump_en        dump window active
//                dump_start     pulse when dump_en rises
//                dump_stop      pulse when dump_en falls
//                done           window completed (sticky until reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dump_trig
    import jtframe_dump_pkg::*;
#(
    parameter int CW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int VS_NEG      = 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          downloading,
    input  logic          cfg_mode,
    input  logic [CW-1:0] cfg_start,
    input  logic [CW-1:0] cfg_len,
    output logic [CW-1:0] frame_cnt,
    output logic          frame_stb,
    output logic          dump_en,
    output logic          dump_start,
    output logic          dump_stop,
    output logic          done
);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic w_vs_level_unused;
    logic w_vs_rise;
    logic w_vs_fall;
    logic w_dl_level;
    logic w_dl_rise;
    logic w_dl_fall;
    logic w_frame_edge;

    jtframe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (vs),
        .o_level (w_vs_level_unused),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    jtframe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (downloading),
        .o_level (w_dl_level),
        .o_rise  (w_dl_rise),
        .o_fall  (w_dl_fall)
    );

    assign w_frame_edge = (VS_NEG != 0) ? w_vs_fall : w_vs_rise;

    // ------------------------------------------------------------------
    // Configuration shadow: captured once, on the single IDLE cycle that
    // follows reset release.
    // ------------------------------------------------------------------
    dump_state_t   r_state;
    dump_state_t   w_state_nxt;
    logic          r_cfg_mode;
    logic [CW-1:0] r_cfg_start;
    logic [CW-1:0] r_cfg_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_mode  <= MODE_FRAME;
            r_cfg_start <= '0;
            r_cfg_len   <= '0;
        end else if (r_state == IDLE) begin
            r_cfg_mode  <= cfg_mode;
            r_cfg_start <= cfg_start;
            r_cfg_len   <= cfg_len;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter: a download end clears it, overriding an increment
    // ------------------------------------------------------------------
    logic [CW-1:0] r_frame_cnt;
    logic          r_frame_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_frame_stb <= 1'b0;
        end else begin
            r_frame_stb <= w_frame_edge;
            if (w_dl_fall)
                r_frame_cnt <= '0;
            else if (w_frame_edge)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frames-in-window counter, held at zero outside DUMP
    // ------------------------------------------------------------------
    logic [CW-1:0] r_win_cnt;
    logic [CW-1:0] w_win_next;

    assign w_win_next = r_win_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_win_cnt <= '0;
        else if (r_state != DUMP)
            r_win_cnt <= '0;
        else if (w_frame_edge)
            r_win_cnt <= w_win_next;
    end

    // ------------------------------------------------------------------
    // Window FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // The start match uses r_frame_cnt before this edge's increment, i.e.
    // the number of the frame that is ending.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // shadow registers load on this same edge, so use the port
                w_state_nxt = (cfg_mode == MODE_DL) ? WAIT_DL : ARMED;
            end
            WAIT_DL: begin
                if (w_dl_fall)
                    w_state_nxt = DUMP;
            end
            ARMED: begin
                if (w_frame_edge && !w_dl_level && (r_frame_cnt == r_cfg_start))
                    w_state_nxt = DUMP;
            end
            DUMP: begin
                // a new download aborts the window and beats a window end
                if (w_dl_rise)
                    w_state_nxt = (r_cfg_mode == MODE_DL) ? WAIT_DL : ARMED;
                else if (w_frame_edge && (r_cfg_len != '0) && (w_win_next == r_cfg_len))
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, all derived from the state transition
    // ------------------------------------------------------------------
    logic r_dump_en;
    logic r_dump_start;
    logic r_dump_stop;
    logic r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dump_en    <= 1'b0;
            r_dump_start <= 1'b0;
            r_dump_stop  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_dump_en    <= (w_state_nxt == DUMP);
            r_dump_start <= (w_state_nxt == DUMP) && (r_state != DUMP);
            r_dump_stop  <= (r_state == DUMP) && (w_state_nxt != DUMP);
            r_done       <= (w_state_nxt == DONE);
        end
    end

    assign frame_cnt  = r_frame_cnt;
    assign frame_stb  = r_frame_stb;
    assign dump_en    = r_dump_en;
    assign dump_start = r_dump_start;
    assign dump_stop  = r_dump_stop;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_dump_trig.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_dump_trig
//  Description : Self-checking bench for jtframe_dump_trig (CW=8 build).
//                Every input change is logged with the cycle at which its
//                effect must appear; a frame-level reference model follows
//                those events and every output is compared each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_dump_trig;

    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int LAT  = SS + 1;      // sample edge -> visible output
    localparam int MAXC = 30000;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_ARMED = 2;
    localparam int P_DUMP  = 3;
    localparam int P_DONE  = 4;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          vs          = 1'b0;
    logic          downloading = 1'b0;
    logic          cfg_mode    = 1'b0;
    logic [CW-1:0] cfg_start   = '0;
    logic [CW-1:0] cfg_len     = '0;
    logic [CW-1:0] frame_cnt;
    logic          frame_stb;
    logic          dump_en;
    logic          dump_start;
    logic          dump_stop;
    logic          done;

    jtframe_dump_trig #(
        .CW          (CW),
        .SYNC_STAGES (SS),
        .VS_NEG      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs          (vs),
        .downloading (downloading),
        .cfg_mode    (cfg_mode),
        .cfg_start   (cfg_start),
        .cfg_len     (cfg_len),
        .frame_cnt   (frame_cnt),
        .frame_stb   (frame_stb),
        .dump_en     (dump_en),
        .dump_start  (dump_start),
        .dump_stop   (dump_stop),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    // events keyed by the cycle their effect becomes visible
    bit ev_fr [MAXC];
    bit ev_dr [MAXC];
    bit ev_df [MAXC];

    // reference model
    int m_phase, m_fc, m_win, m_mode, m_start, m_len;
    bit m_lvl, m_cap;
    bit e_stb, e_en, e_start, e_stop, e_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic m_reset();
        m_phase = P_IDLE; m_fc = 0; m_win = 0; m_lvl = 0; m_cap = 1;
        e_stb = 0; e_en = 0; e_start = 0; e_stop = 0; e_done = 0;
        for (int i = cyc; i < MAXC; i++) begin
            ev_fr[i] = 0; ev_dr[i] = 0; ev_df[i] = 0;
        end
    endtask

    task automatic m_step();
        bit fr, dr, df;
        int fc0;
        fr = ev_fr[cyc]; dr = ev_dr[cyc]; df = ev_df[cyc];
        e_stb = fr; e_start = 0; e_stop = 0;
        if (dr) m_lvl = 1;
        if (df) m_lvl = 0;
        fc0 = m_fc;
        if (m_cap) begin
            m_cap   = 0;
            m_mode  = int'(cfg_mode);
            m_start = int'(cfg_start);
            m_len   = int'(cfg_len);
            m_phase = (m_mode == 1) ? P_WAIT : P_ARMED;
        end else begin
            case (m_phase)
                P_WAIT:  if (df) begin m_phase = P_DUMP; m_win = 0; e_start = 1; end
                P_ARMED: if (fr && !m_lvl && fc0 == m_start) begin
                             m_phase = P_DUMP; m_win = 0; e_start = 1;
                         end
                P_DUMP:  if (dr) begin
                             e_stop = 1; m_phase = (m_mode == 1) ? P_WAIT : P_ARMED;
                         end else if (fr) begin
                             m_win++;
                             if (m_len != 0 && m_win == m_len) begin
                                 e_stop = 1; m_phase = P_DONE;
                             end
                         end
                default: ;
            endcase
        end
        if (df)      m_fc = 0;
        else if (fr) m_fc = (m_fc + 1) % (1 << CW);
        e_en   = (m_phase == P_DUMP);
        e_done = (m_phase == P_DONE);
    endtask

    task automatic cmp_all(input string pfx);
        check({pfx, "frame_cnt"},  32'(frame_cnt),  32'(m_fc));
        check({pfx, "frame_stb"},  32'(frame_stb),  32'(e_stb));
        check({pfx, "dump_en"},    32'(dump_en),    32'(e_en));
        check({pfx, "dump_start"}, 32'(dump_start), 32'(e_start));
        check({pfx, "dump_stop"},  32'(dump_stop),  32'(e_stop));
        check({pfx, "done"},       32'(done),       32'(e_done));
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rst_n) m_step();
        cmp_all("");
    end

    // ---------------- stimulus helpers (drive on negedge) ----------------
    function automatic int tgt();
        return cyc + 1 + LAT;
    endfunction

    task automatic frame(input int gap, input bit dl_toggle);
        @(negedge clk); vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        if (tgt() < MAXC) ev_fr[tgt()] = 1;
        if (dl_toggle) begin
            downloading = ~downloading;
            if (tgt() < MAXC) begin
                if (downloading) ev_dr[tgt()] = 1; else ev_df[tgt()] = 1;
            end
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) frame(gap, 1'b0);
    endtask

    task automatic dl_set(input bit v);
        @(negedge clk);
        if (downloading != v) begin
            downloading = v;
            if (tgt() < MAXC) begin
                if (v) ev_dr[tgt()] = 1; else ev_df[tgt()] = 1;
            end
        end
    endtask

    task automatic settle();
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic do_reset(input bit mode, input int start, input int len);
        @(negedge clk);
        rst_n     = 1'b0;
        cfg_mode  = mode;
        cfg_start = CW'(start);
        cfg_len   = CW'(len);
        m_reset();
        #1;
        cmp_all("rst_");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();

        // 1: five frames, start far away -> count only
        do_reset(1'b0, 100, 0);
        frames(5, 2);
        settle();
        check("t1_cnt", 32'(frame_cnt), 32'd5);
        check("t1_en",  32'(dump_en),   32'd0);

        // 2: start=3 len=2 -> open 3->4, close with done 5->6
        do_reset(1'b0, 3, 2);
        frames(8, 2);
        settle();
        check("t2_done", 32'(done),      32'd1);
        check("t2_cnt",  32'(frame_cnt), 32'd8);

        // 3: download mode, unlimited window
        do_reset(1'b1, 0, 0);
        frames(7, 1);
        dl_set(1'b1);
        frames(2, 1);
        dl_set(1'b0);
        settle();
        check("t3_clr", 32'(frame_cnt), 32'd0);
        check("t3_en",  32'(dump_en),   32'd1);
        frames(50, 1);
        settle();
        check("t3_en50",  32'(dump_en),   32'd1);
        check("t3_cnt50", 32'(frame_cnt), 32'd50);

        // 4: window end coincides with download rise -> abort, re-arm
        do_reset(1'b0, 2, 3);
        frames(5, 2);
        frame(2, 1'b1);
        settle();
        check("t4_done", 32'(done),    32'd0);
        check("t4_en",   32'(dump_en), 32'd0);
        frames(1, 2);
        dl_set(1'b0);
        settle();
        frames(3, 2);
        settle();
        check("t4_reopen", 32'(dump_en), 32'd1);

        // 5: wrap 255->0 opens the window
        do_reset(1'b0, 255, 1);
        frames(256, 1);
        settle();
        check("t5_cnt", 32'(frame_cnt), 32'd0);
        check("t5_en",  32'(dump_en),   32'd1);
        frames(1, 1);
        settle();
        check("t5_done", 32'(done), 32'd1);

        // 6: reset mid-window, then re-sampled config
        do_reset(1'b0, 1, 0);
        frames(3, 2);
        settle();
        check("t6_en", 32'(dump_en), 32'd1);
        do_reset(1'b0, 2, 1);
        frames(4, 2);
        settle();
        check("t6_done", 32'(done), 32'd1);

        // 7: randomized runs
        for (int r = 0; r < 6; r++) begin
            do_reset(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                     int'($urandom_range(0, 4)));
            repeat (3) @(negedge clk);
            cfg_mode  = 1'($urandom_range(0, 1));
            cfg_start = CW'($urandom_range(0, 255));
            cfg_len   = CW'($urandom_range(0, 255));
            for (int a = 0; a < 150; a++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: frame(int'($urandom_range(0, 3)), 1'b0);
                    6, 7:             dl_set(~downloading);
                    8:                frame(int'($urandom_range(0, 3)), 1'b1);
                    default:          repeat ($urandom_range(1, 4)) @(negedge clk);
                endcase
            end
            settle();
            dl_set(1'b0);
            settle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
